// File: rtl/wptr_full.sv
// wptr_full: write-domain pointer and status generator for an asynchronous FIFO.
// Owns the binary/Gray write pointers, produces the memory write address, and
// derives full, almost-full, fill level and sticky overflow from the read
// pointer that has already been synchronised into wclk. All outputs are
// registered; nothing combinational reaches a port from winc or wq2_rptr.
//
// Handshake: the producer raises winc; a write is accepted on any rising edge
// where winc=1 and wfull=0 (wen). The memory captures data at that edge using
// the pre-edge waddr. A winc while wfull=1 is dropped and latches woverflow.
module wptr_full #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 14
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    // Pointer width carries one extra wrap-parity bit above the address bits.
    localparam int PW  = ADDR_WIDTH + 1;
    localparam int MSB = ADDR_WIDTH;

    // Threshold sized to the level width so the compare is unsigned and exact.
    localparam logic [ADDR_WIDTH:0] AFULL_LVL = PW'(AFULL_THRESH);

    // State registers and their next-state values.
    logic [ADDR_WIDTH:0] wbin_q,  wbin_d;
    logic [ADDR_WIDTH:0] wgray_q, wgray_d;
    logic [ADDR_WIDTH:0] wlevel_q, wlevel_d;
    logic                wfull_q, wfull_d;
    logic                wafull_q, wafull_d;
    logic                wovf_q,  wovf_d;

    // Combinational helpers.
    logic                wen;
    logic [ADDR_WIDTH:0] wbinnext;
    logic [ADDR_WIDTH:0] wgraynext;
    logic [ADDR_WIDTH:0] rbin;
    logic [ADDR_WIDTH:0] rgray_full;
    logic [ADDR_WIDTH:0] level_next;

    // Gray-to-binary of the synchronised read pointer: each binary bit is the
    // XOR of all Gray bits at and above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    // Write acceptance, next pointers, and the level/full terms derived from them.
    always_comb begin
        wen        = winc & ~wfull_q;
        wbinnext   = wbin_q + PW'(wen);
        wgraynext  = wbinnext ^ (wbinnext >> 1);
        // A write pointer exactly one lap ahead of the read pointer has its two
        // top Gray bits inverted relative to it and the rest identical.
        rgray_full = {~wq2_rptr[MSB], ~wq2_rptr[MSB-1], wq2_rptr[MSB-2:0]};
        // Modular difference; the parity bit lets it reach the full depth.
        level_next = wbinnext - rbin;
    end

    // Next-state for every register; a rejected write holds the pointers.
    always_comb begin
        wbin_d   = wbinnext;
        wgray_d  = wgraynext;
        wfull_d  = (wgraynext == rgray_full);
        wlevel_d = level_next;
        wafull_d = (level_next >= AFULL_LVL);
        wovf_d   = wovf_q | (winc & wfull_q);
    end

    // State register with synchronous active-low reset that drops all pointer state.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    // Outputs come straight from registers.
    assign waddr        = wbin_q[ADDR_WIDTH-1:0];
    assign wptr         = wgray_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = wovf_q;

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full with a reference model feeding an expected queue.
module tb_wptr_full;

    localparam int AW = 4;
    localparam int PW = AW + 1;
    localparam int W  = 17; // {waddr[4], wptr[5], wfull, walmost_full, wlevel[5], woverflow}

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic          winc;
    logic [PW-1:0] wq2_rptr;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr;
    logic          wfull;
    logic          walmost_full;
    logic [PW-1:0] wlevel;
    logic          woverflow;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];

    // Reference state: binary write count, read position, and latched flags.
    int   m_wbin  = 0;
    int   m_level = 0;
    logic m_full  = 1'b0;
    logic m_ovf   = 1'b0;
    int   rd_bin  = 0;

    wptr_full #(.ADDR_WIDTH(AW), .AFULL_THRESH(14)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    // Clock and watchdog.
    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [PW-1:0] to_gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pop one expected record and compare every output field.
    task automatic check_outputs();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: observed=empty_queue required=entry");
        end else begin
            e = exp_q.pop_front();
            chk("waddr",        8'(waddr),        8'(e[16:13]));
            chk("wptr",         8'(wptr),         8'(e[12:8]));
            chk("wfull",        8'(wfull),        8'(e[7]));
            chk("walmost_full", 8'(walmost_full), 8'(e[6]));
            chk("wlevel",       8'(wlevel),       8'(e[5:1]));
            chk("woverflow",    8'(woverflow),    8'(e[0]));
        end
    endtask

    // Drive one cycle of stimulus, predict the post-edge outputs, then check.
    task automatic step(input logic rst_n, input logic inc, input int rb);
        logic         wen;
        int           nxt;
        logic [W-1:0] e;
        @(negedge wclk);
        wrst_n   = rst_n;
        winc     = inc;
        rd_bin   = rb % 32;
        wq2_rptr = to_gray(rd_bin);
        if (!rst_n) begin
            m_wbin = 0; m_level = 0; m_full = 1'b0; m_ovf = 1'b0;
        end else begin
            wen     = inc && !m_full;
            m_ovf   = m_ovf | (inc && m_full);
            nxt     = (m_wbin + (wen ? 1 : 0)) % 32;
            m_level = (nxt - rd_bin + 32) % 32;
            m_full  = (m_level == 16);
            m_wbin  = nxt;
        end
        e = {4'(m_wbin % 16), to_gray(m_wbin), m_full, (m_level >= 14),
             5'(m_level), m_ovf};
        exp_q.push_back(e);
        @(posedge wclk);
        #1;
        check_outputs();
    endtask

    initial begin
        wrst_n   = 1'b0;
        winc     = 1'b1;
        wq2_rptr = '0;

        // Reset held with winc asserted, then released idle.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 0);

        // Fill from empty with 16 back-to-back writes.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 0);
            if (i == 12) chk("afull_before_14", 8'(walmost_full), 8'd0);
            if (i == 13) chk("afull_at_14",     8'(walmost_full), 8'd1);
        end
        chk("full_wptr",  8'(wptr),   8'h18);
        chk("full_flag",  8'(wfull),  8'd1);
        chk("full_level", 8'(wlevel), 8'd16);
        chk("full_waddr", 8'(waddr),  8'd0);

        // Writes against a full FIFO are rejected and latch overflow.
        step(1'b1, 1'b1, 0);
        chk("ovf_first", 8'(woverflow), 8'd1);
        step(1'b1, 1'b1, 0);
        chk("ovf_wptr",  8'(wptr),      8'h18);
        step(1'b1, 1'b0, 1);
        chk("drain_full",  8'(wfull),     8'd0);
        chk("drain_level", 8'(wlevel),    8'd15);
        chk("drain_ovf",   8'(woverflow), 8'd1);

        // Wrap-around with the reader trailing four entries behind.
        step(1'b1, 1'b0, 12);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, m_wbin + 1 - 4 + 32);
        end
        chk("wrap_level", 8'(wlevel), 8'd4);
        chk("wrap_waddr", 8'(waddr),  8'd8);

        // Bring level to 8, then write and read in the same cycle.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, rd_bin);
        chk("pre_sim_level", 8'(wlevel), 8'd8);
        step(1'b1, 1'b1, rd_bin + 1);
        chk("sim_level", 8'(wlevel), 8'd8);
        chk("sim_wptr",  8'(wptr),   8'(to_gray(29)));

        // Reset mid-stream at level 10 with a pending write.
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, rd_bin);
        chk("pre_rst_level", 8'(wlevel), 8'd10);
        step(1'b0, 1'b1, rd_bin);
        chk("rst_waddr", 8'(waddr),  8'd0);
        chk("rst_level", 8'(wlevel), 8'd0);
        step(1'b1, 1'b1, 0);
        chk("post_rst_waddr", 8'(waddr), 8'd1);

        // Randomised traffic with a reader that never overtakes the writer.
        for (int i = 0; i < 60; i++) begin
            int rb;
            rb = rd_bin;
            if (m_level > 0 && $urandom_range(0, 2) == 0) rb = rd_bin + 1;
            step(1'b1, 1'($urandom_range(0, 1)), rb);
        end

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover: observed=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
